// File: rtl/vram_blit_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vram_blit_ctrl_if                                               |
// | Brief    : Command, Avalon-slave and VRAM port-A bundle of the blit engine |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface vram_blit_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_OP;
  logic [31:0]       CMD_PATTERN;
  logic              BUSY;
  logic              DONE;
  logic              AVL_SEL;
  logic              AVL_WE;
  logic [ADDR_W-1:0] AVL_ADDR;
  logic [3:0]        AVL_BE;
  logic [31:0]       AVL_WDATA;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [3:0]        MEM_BE;
  logic [31:0]       MEM_WDATA;
  logic              MEM_WREN;
  logic              MEM_RDEN;
  logic [31:0]       MEM_Q;

  // master is the system side: command source, Avalon decode and the VRAM itself
  modport master (
    output CMD_VALID, CMD_OP, CMD_PATTERN,
    output AVL_SEL, AVL_WE, AVL_ADDR, AVL_BE, AVL_WDATA,
    output MEM_Q,
    input  CMD_READY, BUSY, DONE,
    input  MEM_ADDR, MEM_BE, MEM_WDATA, MEM_WREN, MEM_RDEN
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_PATTERN,
    input  AVL_SEL, AVL_WE, AVL_ADDR, AVL_BE, AVL_WDATA,
    input  MEM_Q,
    output CMD_READY, BUSY, DONE,
    output MEM_ADDR, MEM_BE, MEM_WDATA, MEM_WREN, MEM_RDEN
  );
endinterface
`default_nettype wire

// File: rtl/vram_blit_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vram_blit_ctrl                                                  |
// | Brief    : FILL/SCROLL sequencer for text VRAM; Avalon always wins port A  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module vram_blit_ctrl #(
  parameter int ROW_WORDS = 40,
  parameter int NUM_ROWS  = 30,
  parameter int RD_LAT    = 2,
  parameter int ADDR_W    = 11
) (
  input  logic           CLK,
  input  logic           RESET_N,
  vram_blit_ctrl_if.slave bus
);

  localparam int                c_LAT_W     = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] c_ROW       = ADDR_W'(ROW_WORDS);
  localparam logic [ADDR_W-1:0] c_LAST_WORD = ADDR_W'(ROW_WORDS * NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] c_LAST_COPY = ADDR_W'(ROW_WORDS * (NUM_ROWS - 1) - 1);
  localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_SC_RD   = 3'd2,
    S_SC_WAIT = 3'd3,
    S_SC_WR   = 3'd4,
    S_SC_TAIL = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_w, w_w_nxt;
  logic [c_LAT_W-1:0]  r_lat, w_lat_nxt;
  logic [31:0]         r_pattern;
  logic [31:0]         r_hold;
  logic                w_grant;
  logic                w_accept;
  logic                w_capture;
  logic                w_eng_wr;
  logic                w_eng_rd;
  logic [ADDR_W-1:0]   w_eng_addr;
  logic [31:0]         w_eng_wdata;

  // Reset also gates the engine so an aborted command writes nothing in the reset cycle
  assign w_grant  = RESET_N & ~bus.AVL_SEL;
  assign w_accept = bus.CMD_VALID & (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_lat_nxt   = r_lat;
    w_capture   = 1'b0;
    w_eng_wr    = 1'b0;
    w_eng_rd    = 1'b0;
    w_eng_addr  = r_w;
    w_eng_wdata = r_pattern;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_w_nxt = '0;
          case (bus.CMD_OP)
            2'b01:   w_state_nxt = S_FILL;
            2'b10:   w_state_nxt = S_SC_RD;
            default: w_state_nxt = S_FIN;
          endcase
        end
      end
      S_FILL, S_SC_TAIL: begin
        if (w_grant) begin
          w_eng_wr = 1'b1;
          if (r_w == c_LAST_WORD) w_state_nxt = S_FIN;
          else                    w_w_nxt     = r_w + ADDR_W'(1);
        end
      end
      S_SC_RD: begin
        w_eng_addr = r_w + c_ROW;
        if (w_grant) begin
          w_eng_rd = 1'b1;
          // MEM_Q is sampled on the RD_LAT-th edge, counting the edge that registers the read
          if (RD_LAT == 1) begin
            w_capture   = 1'b1;
            w_state_nxt = S_SC_WR;
          end else begin
            w_lat_nxt   = c_LAT_W'(1);
            w_state_nxt = S_SC_WAIT;
          end
        end
      end
      S_SC_WAIT: begin
        if (r_lat == c_LAT_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SC_WR;
        end else begin
          w_lat_nxt = r_lat + c_LAT_W'(1);
        end
      end
      S_SC_WR: begin
        w_eng_wdata = r_hold;
        if (w_grant) begin
          w_eng_wr    = 1'b1;
          w_w_nxt     = r_w + ADDR_W'(1);
          w_state_nxt = (r_w == c_LAST_COPY) ? S_SC_TAIL : S_SC_RD;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_w       <= '0;
      r_lat     <= '0;
      r_pattern <= '0;
      r_hold    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_w     <= w_w_nxt;
      r_lat   <= w_lat_nxt;
      if (w_accept)  r_pattern <= bus.CMD_PATTERN;
      if (w_capture) r_hold    <= bus.MEM_Q;
    end
  end

  assign bus.CMD_READY = (r_state == S_IDLE);
  assign bus.BUSY      = (r_state != S_IDLE) && (r_state != S_FIN);
  assign bus.DONE      = (r_state == S_FIN);

  assign bus.MEM_ADDR  = bus.AVL_SEL ? bus.AVL_ADDR  : w_eng_addr;
  assign bus.MEM_BE    = bus.AVL_SEL ? bus.AVL_BE    : 4'hF;
  assign bus.MEM_WDATA = bus.AVL_SEL ? bus.AVL_WDATA : w_eng_wdata;
  assign bus.MEM_WREN  = bus.AVL_SEL ? bus.AVL_WE    : w_eng_wr;
  assign bus.MEM_RDEN  = bus.AVL_SEL ? ~bus.AVL_WE   : w_eng_rd;

endmodule
`default_nettype wire
